inst_fetch_align: RTL
=====================

# inst_fetch_align

Instruction fetch sequencer and halfword realignment buffer for the RV32IC front end. It issues word-aligned reads to instruction memory and rebuilds 16-bit and 32-bit instructions that may straddle word boundaries. It presents one aligned instruction per handshake to the decode stage, which feeds the register file, control unit and ImmGen. It also handles PC redirects from branch and jump resolution.

## Interface
- RESET_PC, 32'h0000_0000, first fetch PC after reset; halfword aligned
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- redirect_valid  in  1  flush buffer and restart fetch at redirect_pc
- redirect_pc  in  32  new PC; bit 0 ignored
- mem_req  out  1  read request; held until mem_ack
- mem_addr  out  32  word address (bits[1:0]=00); stable while mem_req=1
- mem_ack  in  1  mem_rdata valid; completes the request in this cycle (may arrive in the same cycle mem_req rises)
- mem_rdata  in  32  little-endian: halfword at addr = [15:0], at addr+2 = [31:16]
- inst_valid  out  1  inst/inst_pc/inst_is_c valid
- inst  out  32  instruction; compressed is zero-extended in [15:0]; 0 when inst_valid=0
- inst_pc  out  32  PC of inst
- inst_is_c  out  1  1 = 16-bit instruction; 0 when inst_valid=0
- inst_ready  in  1  decode accepts inst this cycle

## Operation
- State:
  - 4-entry halfword queue with count 0..4.
  - fetch_addr, word aligned.
  - head_pc.
  - drop flag.
  - first_odd flag.
- Length rule: head halfword[1:0]!=2'b11 means compressed, need=1; otherwise need=2.
- inst_valid = (count >= need) and not drop-pending-flush.
- Pop on inst_valid && inst_ready:
  - count -= need.
  - head_pc += 2 or 4.
- Request issue:
  - Raise mem_req when count <= 2 and no request is outstanding.
  - At most one request outstanding.
- Fill on mem_ack with drop=0:
  - Append both halfwords (count += 2), fetch_addr += 4.
  - If first_odd=1, discard [15:0], append only [31:16] (count += 1), then clear first_odd.
- A simultaneous pop and fill nets out: count_next = count - pop + fill.
  - Overflow is impossible because issue requires count <= 2.
- Redirect (priority over pop and fill):
  - Next cycle: count=0, head_pc=redirect_pc&~1, fetch_addr=redirect_pc&~3, first_odd=redirect_pc[1].
- Redirect with a request outstanding and no ack this cycle:
  - Set drop=1.
  - mem_req stays high with the old mem_addr until mem_ack; that data is discarded; drop clears.
  - The new address is issued the following cycle at the earliest.
- Redirect in the same cycle as mem_ack: that data is discarded and drop is not set.
- Multiple redirects while drop=1: the last one wins; only the single outstanding response is dropped.
- Reset:
  - mem_req=0, mem_addr=RESET_PC&~3, inst_valid=0, inst=0, inst_is_c=0, inst_pc=RESET_PC, count=0, drop=0, first_odd=RESET_PC[1].
  - A reset mid-request abandons the request; the memory side must also be reset.
- Widths: all PC arithmetic is 32-bit modulo 2^32. Wrap from 0xFFFF_FFFC to 0 is legal.

## Timing
- mem_req asserts in the first cycle after rst deasserts.
- mem_ack to inst_valid latency: 1 cycle (registered queue).
- Steady state: 1 instruction/cycle when memory acks every cycle.
- A straddling 32-bit instruction needs 2 fills; inst_valid rises 1 cycle after the second ack.
- Redirect to first inst_valid is at least 2 cycles with zero-wait memory: redirect cycle, then the request/ack cycle, then valid.
- With inst_ready=0: inst, inst_pc and inst_is_c are held stable. mem_req may still complete one outstanding fill.
- inst_valid never deasserts without a pop, except on redirect or rst.

## Test plan
- Reset, RESET_PC=0, word0=0x00A00093, zero-wait memory → mem_addr=0; next cycle inst_valid=1, inst=0x00A00093, inst_pc=0, inst_is_c=0.
- word0=0x05054501 → inst=0x00004501 at pc 0 (is_c=1), then inst=0x00000505 at pc 2 on consecutive cycles.
- Straddle: word0=0x00934501, word4=0x000500A0 → 0x00004501 at pc 0, then 0x00A00093 at pc 2, valid 1 cycle after the ack for mem_addr=4.
- Redirect to 0x102, word 0x100 = 0x45010000 → mem_addr=0x100, low half discarded, first inst=0x00004501 at inst_pc=0x102.
- Redirect issued while a request is outstanding with a 3-cycle ack delay → mem_addr stays unchanged until ack; stale data is never presented (inst_valid=0); the next request uses the new word address.
- Backpressure: inst_ready=0 for 5 cycles with full queue → outputs stable, mem_req=0 while count>2, no instruction lost or duplicated after release.

Source files
------------

// File: rtl/inst_fetch_align.sv
// -----------------------------------------------------------------------------
// inst_fetch_align
// Instruction fetch sequencer and halfword realignment buffer for an RV32IC
// front end. Word-aligned reads are issued to instruction memory. The returned
// halfwords are queued and rebuilt into 16-bit (compressed) or 32-bit
// instructions, which may straddle word boundaries. Decode receives one aligned
// instruction per valid/ready handshake.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   redirect_valid/_pc    flush the queue and restart fetch at redirect_pc
//   mem_req/_addr         word-aligned read request, held until mem_ack
//   mem_ack/_rdata        read completion and data (little-endian halfwords)
//   inst_valid/inst       aligned instruction; compressed is zero-extended
//   inst_pc/inst_is_c     PC of inst, 1 = 16-bit instruction
//   inst_ready            decode accepts inst this cycle
// -----------------------------------------------------------------------------
module inst_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    input  logic        inst_ready
);

    // Halfword queue, q[0] is the head (oldest halfword).
    logic [15:0] q     [4];
    logic [15:0] q_pop [4];
    logic [15:0] q_nxt [4];

    logic [2:0]  count;
    logic [2:0]  count_nxt;
    logic [2:0]  need;
    logic [2:0]  pop_n;
    logic [2:0]  base;
    logic [1:0]  slot_lo;
    logic [1:0]  slot_hi;
    logic [31:0] fetch_addr;
    logic [31:0] drop_addr;
    logic [31:0] head_pc;
    logic        drop;
    logic        first_odd;
    logic        head_is_c;
    logic        pop;
    logic        fill;
    logic        keep;

    // Decode-side view of the queue head.
    always_comb begin
        head_is_c  = (q[0][1:0] != 2'b11);
        need       = head_is_c ? 3'd1 : 3'd2;
        inst_valid = (count >= need) && !drop;
        if (!inst_valid)
            inst = 32'h0000_0000;
        else if (head_is_c)
            inst = {16'h0000, q[0]};
        else
            inst = {q[1], q[0]};
        inst_is_c  = inst_valid && head_is_c;
        inst_pc    = head_pc;
    end

    // Memory side. While a dropped response is pending, the request stays up
    // on the abandoned address so mem_addr never moves under an open request.
    // The queue cannot overflow: a fresh request needs count <= 2, and count
    // only grows through the fill that completes it.
    always_comb begin
        mem_req  = !rst && (drop || (count <= 3'd2));
        mem_addr = drop ? drop_addr : fetch_addr;
        fill     = mem_req && mem_ack;
        pop      = inst_valid && inst_ready;
        keep     = fill && !drop && !redirect_valid;
    end

    // Pop shifts the queue down, then the fill appends behind what is left.
    always_comb begin
        pop_n   = pop ? need : 3'd0;
        base    = count - pop_n;
        slot_lo = base[1:0];
        slot_hi = base[1:0] + 2'd1;
        case (pop_n)
            3'd1:    q_pop = '{q[1], q[2], q[3], q[3]};
            3'd2:    q_pop = '{q[2], q[3], q[2], q[3]};
            default: q_pop = q;
        endcase
        q_nxt     = q_pop;
        count_nxt = base;
        if (keep) begin
            if (first_odd) begin
                // Fetch began at the upper halfword of this word.
                q_nxt[slot_lo] = mem_rdata[31:16];
                count_nxt      = base + 3'd1;
            end else begin
                q_nxt[slot_lo] = mem_rdata[15:0];
                q_nxt[slot_hi] = mem_rdata[31:16];
                count_nxt      = base + 3'd2;
            end
        end
    end

    // Queue storage carries no reset; count qualifies every entry.
    always_ff @(posedge clk) begin
        q <= q_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count      <= 3'd0;
            head_pc    <= RESET_PC & 32'hFFFF_FFFE;
            fetch_addr <= RESET_PC & 32'hFFFF_FFFC;
            drop_addr  <= RESET_PC & 32'hFFFF_FFFC;
            drop       <= 1'b0;
            first_odd  <= RESET_PC[1];
        end else if (redirect_valid) begin
            count      <= 3'd0;
            head_pc    <= redirect_pc & 32'hFFFF_FFFE;
            fetch_addr <= redirect_pc & 32'hFFFF_FFFC;
            first_odd  <= redirect_pc[1];
            // An open request that is not completing now must be drained
            // and its data thrown away; repeated redirects keep the old address.
            drop       <= mem_req && !mem_ack;
            drop_addr  <= mem_addr;
        end else begin
            count <= count_nxt;
            if (pop)
                head_pc <= head_pc + {28'd0, need, 1'b0};
            if (fill) begin
                if (drop) begin
                    drop <= 1'b0;
                end else begin
                    fetch_addr <= fetch_addr + 32'd4;
                    first_odd  <= 1'b0;
                end
            end
        end
    end

endmodule
